beat_judge: RTL and testbench

- Scoring stage directly downstream of the four-slot arrow buffer; consumes the oldest slot (the arrow the player must hit) plus debounced button levels.
- Each beat: collects button press edges during the beat window, then compares them with the due arrow on the next metronome rising edge.
- Maintains BCD score, combo, miss count and game-over flag; outputs feed the 7-segment score display and the top-level game FSM.

---
 rtl/beat_judge_pkg.sv | 46 ++++
 rtl/beat_judge_bcd_sat_adder4.sv | 31 +++
 rtl/beat_judge.sv | 153 +++++++++++++++
 tb/tb_beat_judge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_judge_pkg.sv
// Shared types for the beat judge: state codes, arrow codes and the
// arrow-to-direction-mask decode.
package beat_judge_pkg;

  typedef enum logic [1:0] {
    STATE_GAME  = 2'd0,
    STATE_PAUSE = 2'd1,
    STATE_RESET = 2'd2
  } state_e;

  // Direction mask bit order is {up, down, left, right}
  typedef logic [3:0] dir_mask_t;

  localparam logic [4:0] ARROW_UP         = 5'd10;
  localparam logic [4:0] ARROW_DOWN       = 5'd11;
  localparam logic [4:0] ARROW_LEFT       = 5'd12;
  localparam logic [4:0] ARROW_RIGHT      = 5'd13;
  localparam logic [4:0] ARROW_UP_DOWN    = 5'd14;
  localparam logic [4:0] ARROW_UP_LEFT    = 5'd15;
  localparam logic [4:0] ARROW_UP_RIGHT   = 5'd16;
  localparam logic [4:0] ARROW_DOWN_LEFT  = 5'd17;
  localparam logic [4:0] ARROW_DOWN_RIGHT = 5'd18;
  localparam logic [4:0] ARROW_LEFT_RIGHT = 5'd19;
  localparam logic [4:0] ARROW_NONE       = 5'd20;

  function automatic dir_mask_t decode_arrow(
    input logic [4:0] code
  );
    dir_mask_t m;
    case (code)
      ARROW_UP:         m = 4'b1000;
      ARROW_DOWN:       m = 4'b0100;
      ARROW_LEFT:       m = 4'b0010;
      ARROW_RIGHT:      m = 4'b0001;
      ARROW_UP_DOWN:    m = 4'b1100;
      ARROW_UP_LEFT:    m = 4'b1010;
      ARROW_UP_RIGHT:   m = 4'b1001;
      ARROW_DOWN_LEFT:  m = 4'b0110;
      ARROW_DOWN_RIGHT: m = 4'b0101;
      ARROW_LEFT_RIGHT: m = 4'b0011;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/beat_judge_bcd_sat_adder4.sv
// Four-digit BCD adder with a small increment, saturating at 9999.
// Purely combinational.
module bcd_sat_adder4 (
  input  logic [15:0] i_a,
  input  logic [1:0]  i_inc,
  output logic [15:0] o_sum
);

  logic [4:0]  w_t;
  logic [1:0]  w_c;
  logic [15:0] w_raw;

  always_comb begin
    w_c   = i_inc;
    w_t   = '0;
    w_raw = '0;
    for (int i = 0; i < 4; i++) begin
      w_t = {1'b0, i_a[4*i +: 4]} + {3'b000, w_c};
      if (w_t > 5'd9) begin
        w_t = w_t - 5'd10;
        w_c = 2'd1;
      end else begin
        w_c = 2'd0;
      end
      w_raw[4*i +: 4] = w_t[3:0];
    end
    // Carry out of the thousands digit means we passed 9999
    o_sum = (w_c != 2'd0) ? 16'h9999 : w_raw;
  end

endmodule

// File: rtl/beat_judge.sv
// Beat scoring stage: captures presses per beat, judges on metronome tick.
// Optional BEAT_JUDGE_HIGH_SCORE_EN adds a high-score register and port.
module beat_judge
  import beat_judge_pkg::*;
#(
  parameter int COMBO_BONUS_AT  = 8,
  parameter int MAX_MISSES      = 10,
  parameter int STATE_BITS      = 1,
  parameter int NUM_ARROWS_BITS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_metronome_clk,
  input  logic [STATE_BITS:0]    i_state,
  input  logic [NUM_ARROWS_BITS:0] i_arrow_due,
  input  logic [3:0]             i_btn,
  output logic [15:0]            o_score_bcd,
  output logic [7:0]             o_combo,
  output logic [3:0]             o_miss_count,
  output logic                   o_hit_pulse,
  output logic                   o_miss_pulse,
  output logic                   o_game_over
`ifdef BEAT_JUDGE_HIGH_SCORE_EN
  ,
  output logic [15:0]            o_high_score_bcd
`endif
);

  localparam logic [3:0] LP_MAX   = 4'(MAX_MISSES);
  localparam logic [7:0] LP_BONUS = 8'(COMBO_BONUS_AT);

  logic [2:0]  r_sync;
  logic        r_tick;
  dir_mask_t   r_btn_prev;
  dir_mask_t   r_press;
  logic [15:0] r_score;
  logic [7:0]  r_combo;
  logic [3:0]  r_miss_cnt;
  logic        r_hit;
  logic        r_miss;
  logic        r_game_over;

  dir_mask_t   w_target;
  dir_mask_t   w_edge;
  logic        w_game;
  logic        w_reset;
  logic        w_hit;
  logic        w_miss;
  logic [1:0]  w_inc;
  logic [15:0] w_score_next;
  logic [3:0]  w_miss_next;

  assign w_game   = (i_state == STATE_GAME);
  assign w_reset  = (i_state == STATE_RESET);
  assign w_target = decode_arrow(5'(i_arrow_due));
  assign w_edge   = i_btn & ~r_btn_prev;

  assign w_hit  = r_tick && (w_target != '0)
                && (r_press == w_target);
  assign w_miss = r_tick && !w_hit
                && !((w_target == '0) && (r_press == '0));

  assign w_inc       = (r_combo >= LP_BONUS) ? 2'd2 : 2'd1;
  assign w_miss_next = r_miss_cnt + 4'd1;

  bcd_sat_adder4 u_add (
    .i_a   (r_score),
    .i_inc (w_inc),
    .o_sum (w_score_next)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync      <= '0;
      r_tick      <= 1'b0;
      r_btn_prev  <= '0;
      r_press     <= '0;
      r_score     <= '0;
      r_combo     <= '0;
      r_miss_cnt  <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
    end else if (w_reset) begin
      r_sync      <= '0;
      r_tick      <= 1'b0;
      r_btn_prev  <= '0;
      r_press     <= '0;
      r_score     <= '0;
      r_combo     <= '0;
      r_miss_cnt  <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      // sync[2] is newest; rising edge is old-low, new-high
      r_sync     <= {i_metronome_clk, r_sync[2:1]};
      r_tick     <= ~r_sync[0] & r_sync[1];
      r_btn_prev <= i_btn;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      if (r_game_over) begin
        r_press <= '0;
      end else if (w_game) begin
        if (r_tick) begin
          r_press <= w_edge;
          if (w_hit) begin
            r_hit   <= 1'b1;
            r_score <= w_score_next;
            if (r_combo != 8'hFF)
              r_combo <= r_combo + 8'd1;
          end else if (w_miss) begin
            r_miss     <= 1'b1;
            r_combo    <= '0;
            r_miss_cnt <= w_miss_next;
            if (w_miss_next == LP_MAX)
              r_game_over <= 1'b1;
          end
        end else begin
          r_press <= r_press | w_edge;
        end
      end
    end
  end

`ifdef BEAT_JUDGE_HIGH_SCORE_EN
  logic [STATE_BITS:0] r_state_prev;
  logic [15:0]         r_high;

  // Packed BCD orders the same as unsigned binary, MSB digit first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state_prev <= '0;
      r_high       <= '0;
    end else begin
      r_state_prev <= i_state;
      if (w_reset && (r_state_prev != STATE_RESET)
          && (r_score > r_high))
        r_high <= r_score;
    end
  end

  assign o_high_score_bcd = r_high;
`endif

  assign o_score_bcd  = r_score;
  assign o_combo      = r_combo;
  assign o_miss_count = r_miss_cnt;
  assign o_hit_pulse  = r_hit;
  assign o_miss_pulse = r_miss;
  assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_beat_judge.sv
// Scoreboard bench for beat_judge: stimulus pushes expected judgements,
// a monitor pops and compares on every hit/miss pulse.
module tb_beat_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        met;
  logic [1:0]  state;
  logic [4:0]  arrow;
  logic [3:0]  btn;
  logic [15:0] o_score;
  logic [7:0]  o_combo;
  logic [3:0]  o_miss;
  logic        o_hit_p;
  logic        o_miss_p;
  logic        o_go;

  beat_judge dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_metronome_clk (met),
    .i_state         (state),
    .i_arrow_due     (arrow),
    .i_btn           (btn),
    .o_score_bcd     (o_score),
    .o_combo         (o_combo),
    .o_miss_count    (o_miss),
    .o_hit_pulse     (o_hit_p),
    .o_miss_pulse    (o_miss_p),
    .o_game_over     (o_go)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [3:0]  miss;
    logic        go;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_score, m_combo, m_miss;
  bit   m_go;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] tb_mask(logic [4:0] a);
    case (a)
      5'd10: return 4'b1000;
      5'd11: return 4'b0100;
      5'd12: return 4'b0010;
      5'd13: return 4'b0001;
      5'd14: return 4'b1100;
      5'd15: return 4'b1010;
      5'd16: return 4'b1001;
      5'd17: return 4'b0110;
      5'd18: return 4'b0101;
      5'd19: return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  // Monitor: every pulse must match the oldest expected judgement
  always @(negedge clk) begin
    if (o_hit_p || o_miss_p) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%b%b required=00",
                 o_hit_p, o_miss_p);
      end else begin
        mon_e = q.pop_front();
        chk("hit_pulse", o_hit_p, mon_e.hit);
        chk("miss_pulse", o_miss_p, !mon_e.hit);
        chk("score", o_score, mon_e.score);
        chk("combo", o_combo, mon_e.combo);
        chk("miss_count", o_miss, mon_e.miss);
        chk("game_over", o_go, mon_e.go);
      end
    end
  end

  task automatic model_clear();
    m_score = 0;
    m_combo = 0;
    m_miss  = 0;
    m_go    = 0;
  endtask

  task automatic expect_beat(logic [4:0] a, logic [3:0] m);
    logic [3:0] t;
    exp_t e;
    int inc;
    if (m_go) return;
    t = tb_mask(a);
    if (t == 4'b0 && m == 4'b0) return;
    if (t == m) begin
      inc = (m_combo >= 8) ? 2 : 1;
      m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
      if (m_combo < 255) m_combo++;
      e.hit = 1'b1;
    end else begin
      m_combo = 0;
      m_miss++;
      if (m_miss == 10) m_go = 1;
      e.hit = 1'b0;
    end
    e.score = to_bcd(m_score);
    e.combo = 8'(m_combo);
    e.miss  = 4'(m_miss);
    e.go    = m_go;
    q.push_back(e);
  endtask

  // Rise, hold two cycles, fall; returns just after the judging edge
  task automatic tick_beat();
    met = 1'b1;
    repeat (2) @(negedge clk);
    met = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic beat(logic [4:0] a, logic [3:0] m);
    arrow = a;
    expect_beat(a, m);
    btn = m;
    @(negedge clk);
    btn = 4'b0;
    tick_beat();
  endtask

  task automatic beat_split(logic [4:0] a, logic [3:0] m);
    arrow = a;
    expect_beat(a, m);
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) begin
        btn = 4'b0;
        btn[i] = 1'b1;
        @(negedge clk);
        btn = 4'b0;
        @(negedge clk);
      end
    end
    tick_beat();
  endtask

  task automatic hits(int n);
    repeat (n) beat(5'd10, 4'b1000);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_score"}, o_score, 16'h0);
    chk({tag, "_combo"}, o_combo, 8'h0);
    chk({tag, "_miss"}, o_miss, 4'h0);
    chk({tag, "_hitp"}, o_hit_p, 1'b0);
    chk({tag, "_missp"}, o_miss_p, 1'b0);
    chk({tag, "_go"}, o_go, 1'b0);
  endtask

  task automatic game_reset();
    state = 2'd2;
    @(negedge clk);
    state = 2'd0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    met   = 1'b0;
    state = 2'd0;
    arrow = 5'd20;
    btn   = 4'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two-button arrow pressed one button at a time
    beat_split(5'd16, 4'b1001);
    chk("ur_score", o_score, 16'h0001);
    chk("ur_combo", o_combo, 8'd1);
    hits(4);
    beat(5'd10, 4'b1010);
    chk("wrong_combo", o_combo, 8'd0);
    chk("wrong_miss", o_miss, 4'd1);
    chk("wrong_score", o_score, 16'h0005);
    beat(5'd20, 4'b0000);
    beat(5'd5, 4'b0100);
    beat(5'd19, 4'b0011);

    // Held button counts only in the beat it went down
    arrow = 5'd10;
    expect_beat(5'd10, 4'b1000);
    btn = 4'b1000;
    @(negedge clk);
    tick_beat();
    expect_beat(5'd10, 4'b0000);
    tick_beat();
    btn = 4'b0;
    @(negedge clk);
    chk("held_miss", o_miss, 4'd3);

    // Pause holds the captured mask and ignores the tick
    arrow = 5'd10;
    btn = 4'b1000;
    @(negedge clk);
    btn = 4'b0;
    state = 2'd1;
    @(negedge clk);
    btn = 4'b0100;
    @(negedge clk);
    btn = 4'b0;
    tick_beat();
    chk("pause_combo", o_combo, 8'd0);
    state = 2'd0;
    expect_beat(5'd10, 4'b1000);
    tick_beat();
    chk("resume_score", o_score, 16'h0008);

    game_reset();
    check_zero("state_reset");

    // Score 0042 combo 3, then async reset mid-beat
    hits(23);
    beat(5'd10, 4'b0);
    hits(1);
    beat(5'd10, 4'b0);
    hits(3);
    chk("pre_rst_score", o_score, 16'h0042);
    chk("pre_rst_combo", o_combo, 8'd3);
    arrow = 5'd20;
    btn = 4'b1000;
    @(negedge clk);
    btn = 4'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    tick_beat();
    chk("post_rst_pulse", {o_hit_p, o_miss_p}, 2'b00);

    // Bonus threshold: 0099 at combo 8 -> 0101
    game_reset();
    hits(49);
    beat(5'd10, 4'b0);
    hits(1);
    beat(5'd10, 4'b0);
    hits(8);
    chk("s99_score", o_score, 16'h0099);
    chk("s99_combo", o_combo, 8'd8);
    hits(1);
    chk("s101_score", o_score, 16'h0101);
    chk("s101_combo", o_combo, 8'd9);

    // Saturation at 9999 and combo at 255
    game_reset();
    hits(8);
    chk("b8_score", o_score, 16'h0008);
    hits(1);
    chk("b9_score", o_score, 16'h0010);
    hits(4994);
    chk("s9998", o_score, 16'h9998);
    hits(1);
    chk("s9999", o_score, 16'h9999);
    hits(1);
    chk("s9999_hold", o_score, 16'h9999);
    chk("combo_sat", o_combo, 8'd255);

    // Ten misses end the game; later beats change nothing
    repeat (9) beat(5'd10, 4'b0);
    chk("nine_go", o_go, 1'b0);
    chk("nine_miss", o_miss, 4'd9);
    beat(5'd20, 4'b1000);
    chk("go_set", o_go, 1'b1);
    chk("go_miss", o_miss, 4'd10);
    beat(5'd10, 4'b1000);
    beat(5'd10, 4'b1000);
    chk("frozen_score", o_score, 16'h9999);
    chk("frozen_combo", o_combo, 8'd0);
    chk("frozen_miss", o_miss, 4'd10);
    chk("frozen_go", o_go, 1'b1);
    game_reset();
    check_zero("go_reset");

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
